// File: rtl/bus_rr_scheduler.sv
// Round-robin bus scheduler: grants one pending device, pops its head packet and
// pushes it to the decoded destination (or all other devices on broadcast).

module bus_rr_lane #(
  parameter int          IDX       = 0,
  parameter logic [7:0]  BROADCAST = 8'hFF
) (
  input  logic [3:0] winner,
  input  logic [3:0] grant,
  input  logic [7:0] dest,
  output logic       pop_bit,
  output logic       push_bit
);
  assign pop_bit  = (winner == 4'(IDX));
  // The source never receives its own packet; an out-of-range dest matches no lane.
  assign push_bit = (dest == BROADCAST) ? (grant != 4'(IDX))
                                        : ((dest == 8'(IDX)) && (grant != 4'(IDX)));
endmodule

module bus_rr_scheduler #(
  parameter int         DRVRS     = 5,
  parameter int         PCKG_SZ   = 32,
  parameter logic [7:0] BROADCAST = 8'hFF
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [DRVRS-1:0]                pndng,
  input  logic [DRVRS-1:0][PCKG_SZ-1:0]   D_pop,
  output logic [DRVRS-1:0]                pop,
  output logic [DRVRS-1:0]                push,
  output logic [DRVRS-1:0][PCKG_SZ-1:0]   D_push,
  output logic                            busy,
  output logic [3:0]                      grant_id,
  output logic [15:0]                     pkt_cnt,
  output logic [15:0]                     drop_cnt
);
  typedef enum logic [1:0] {IDLE, POP, PUSH} state_t;

  state_t               state, state_nxt;
  logic [3:0]           winner;
  logic                 found;
  logic [PCKG_SZ-1:0]   head, pkt;
  logic [DRVRS-1:0]     pop_mask, pop_mask_nxt, push_mask, push_mask_nxt;

  // Two passes: devices above the last grant first, then wrap to the bottom.
  always_comb begin
    winner = grant_id;
    found  = 1'b0;
    for (int i = 0; i < DRVRS; i++)
      if (!found && pndng[i] && (4'(i) > grant_id)) begin
        winner = 4'(i);
        found  = 1'b1;
      end
    for (int i = 0; i < DRVRS; i++)
      if (!found && pndng[i] && (4'(i) <= grant_id)) begin
        winner = 4'(i);
        found  = 1'b1;
      end
  end

  always_comb begin
    head = '0;
    for (int i = 0; i < DRVRS; i++)
      if (grant_id == 4'(i)) head = D_pop[i];
  end

  for (genvar i = 0; i < DRVRS; i++) begin : g_lane
    bus_rr_lane #(.IDX(i), .BROADCAST(BROADCAST)) u_lane (
      .winner   (winner),
      .grant    (grant_id),
      .dest     (head[PCKG_SZ-1 -: 8]),
      .pop_bit  (pop_mask_nxt[i]),
      .push_bit (push_mask_nxt[i])
    );
    assign D_push[i] = pkt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = POP;
      POP:     state_nxt = PUSH;
      PUSH:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      grant_id  <= 4'(DRVRS-1);
      pop_mask  <= '0;
      push_mask <= '0;
      pkt       <= '0;
      pkt_cnt   <= '0;
      drop_cnt  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (found) begin
          grant_id <= winner;
          pop_mask <= pop_mask_nxt;
        end
        POP: begin
          pkt       <= head;
          push_mask <= push_mask_nxt;
        end
        PUSH: begin
          // An empty mask means the packet was dropped.
          if (|push_mask) begin
            if (pkt_cnt != 16'hFFFF) pkt_cnt <= pkt_cnt + 16'd1;
          end else begin
            if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign pop  = (state == POP)  ? pop_mask  : '0;
  assign push = (state == PUSH) ? push_mask : '0;
  assign busy = (state != IDLE);
endmodule

// File: tb/tb_bus_rr_scheduler.sv
// Directed + randomized bench for bus_rr_scheduler with a transaction-level model.

module tb_bus_rr_scheduler;
  localparam int N = 5;

  logic              clk = 0;
  logic              reset;
  logic [N-1:0]      pndng;
  logic [N-1:0][31:0] D_pop;
  logic [N-1:0]      pop, push;
  logic [N-1:0][31:0] D_push;
  logic              busy;
  logic [3:0]        grant_id;
  logic [15:0]       pkt_cnt, drop_cnt;

  int passed = 0, total = 0, fails = 0;
  int last = N-1, exp_pkt = 0, exp_drop = 0;

  bus_rr_scheduler #(.DRVRS(N), .PCKG_SZ(32), .BROADCAST(8'hFF)) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .pop(pop), .push(push),
    .D_push(D_push), .busy(busy), .grant_id(grant_id), .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input int from, input logic [N-1:0] pn);
    for (int k = 1; k <= N; k++)
      if (pn[(from + k) % N]) return (from + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] route(input int src, input logic [31:0] p);
    int d = int'(p[31:24]);
    if (d == 255) return ~(N'(1) << src);
    if (d < N && d != src) return N'(1) << d;
    return '0;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  // One arbitration window starting from IDLE, inputs held for the whole packet.
  task automatic txn(input logic [N-1:0] pn, input logic [N-1:0][31:0] dp);
    int w;
    logic [N-1:0] m;
    pndng = pn; D_pop = dp;
    w = pick(last, pn);
    step();
    if (w < 0) begin
      chk("idle_busy", busy, 0);
      chk("idle_grant", grant_id, 4'(last));
      return;
    end
    chk("pop_vec", pop, N'(1) << w);
    chk("grant", grant_id, 4'(w));
    chk("busy_pop", busy, 1);
    chk("push_in_pop", push, 0);
    last = w;
    m = route(w, dp[w]);
    step();
    chk("push_vec", push, m);
    chk("pop_in_push", pop, 0);
    for (int i = 0; i < N; i++) chk("d_push", D_push[i], dp[w]);
    chk("pkt_cnt_hold", pkt_cnt, 16'(exp_pkt));
    if (m != 0) exp_pkt++; else exp_drop++;
    step();
    chk("busy_idle", busy, 0);
    chk("pop_idle", pop, 0);
    chk("push_idle", push, 0);
    chk("pkt_cnt", pkt_cnt, 16'(exp_pkt));
    chk("drop_cnt", drop_cnt, 16'(exp_drop));
  endtask

  function automatic logic [31:0] rnd_pkt();
    logic [7:0] d;
    case ($urandom_range(0, 3))
      0, 1:    d = 8'($urandom_range(0, N-1));
      2:       d = 8'hFF;
      default: d = 8'($urandom_range(0, 255));
    endcase
    return {d, 24'($urandom)};
  endfunction

  initial begin
    logic [N-1:0][31:0] dp;
    reset = 0; pndng = '0; D_pop = '0;
    // Reset state under random pending requests.
    for (int c = 0; c < 3; c++) begin
      pndng = N'($urandom);
      step();
      chk("rst_pop", pop, 0);
      chk("rst_push", push, 0);
      chk("rst_busy", busy, 0);
      chk("rst_grant", grant_id, 4);
      chk("rst_pkt", pkt_cnt, 0);
      chk("rst_drop", drop_cnt, 0);
      chk("rst_dpush", D_push[0], 0);
    end
    pndng = '0; reset = 1;
    step();

    // Unicast 1 -> 3.
    dp = '0; dp[1] = 32'h0300_00AB;
    txn(5'b00010, dp);

    // Everyone pending: five back-to-back grants.
    for (int r = 0; r < N; r++) begin
      for (int i = 0; i < N; i++) dp[i] = rnd_pkt();
      txn('1, dp);
    end

    // Broadcast from device 2.
    dp = '0; dp[2] = 32'hFF12_3456;
    txn(5'b00100, dp);

    // Drops: out-of-range dest, then dest == source.
    dp = '0; dp[0] = 32'h0700_0001;
    txn(5'b00001, dp);
    dp = '0; dp[4] = 32'h0400_0002;
    txn(5'b10000, dp);

    // Randomized traffic, including idle windows.
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < N; i++) dp[i] = rnd_pkt();
      txn(N'($urandom), dp);
    end

    // Reset during PUSH of a unicast must kill the push immediately.
    dp = '0; dp[1] = 32'h0300_0055;
    pndng = 5'b00010; D_pop = dp;
    last = pick(last, pndng);
    step();
    step();
    chk("push_before_rst", push, 5'b01000);
    reset = 0; #1;
    chk("async_push", push, 0);
    chk("async_busy", busy, 0);
    chk("async_pkt", pkt_cnt, 0);
    chk("async_grant", grant_id, 4);
    last = N-1; exp_pkt = 0; exp_drop = 0;
    #2 reset = 1;
    dp = '0; dp[0] = 32'h0300_0011; dp[3] = 32'h0000_0022;
    txn(5'b01001, dp);
    chk("post_rst_first", last, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
